vram_term_writer: RTL and testbench

//  Terminal write controller for port A of the 64x32-character video RAM (2048 x 9 bit).

---
 rtl/vram_term_writer.sv | 219 +++++++++++++++++++++
 tb/tb_vram_term_writer.sv | 335 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vram_term_writer.sv
// vram_term_writer
//   Terminal write controller for port A of a 64x32 character video RAM
//   (2048 words of 9 bits). It takes bytes from a UART receiver and turns
//   them into character writes, cursor moves, scrolling and screen clears.
//   Port B of the RAM belongs to the video scan-out, which uses the
//   exported scroll offset and cursor position.
//
// Ports
//   clk        system clock, also clocks VRAM port A
//   reset      synchronous, active-high reset
//   rx_valid   byte available from the UART
//   rx_data    received byte
//   rx_ready   byte is taken on a cycle where rx_valid & rx_ready
//   attr       attribute bit stored as bit 8 of a written character
//   vram_ada   port A address {phys_row, col}
//   vram_dina  port A write data
//   vram_wrea  port A write enable, one cycle per word
//   vram_cea   port A clock enable, follows vram_wrea
//   scroll_row physical row displayed as the top screen line
//   cur_col    cursor column
//   cur_row    cursor row, logical (0 = top of screen)
//   busy       high while a full-screen or single-line clear runs
module vram_term_writer #(
  parameter int         COL_BITS   = 6,
  parameter int         ROW_BITS   = 5,
  parameter logic [8:0] BLANK_WORD = 9'h020
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         rx_valid,
  input  logic [7:0]                   rx_data,
  output logic                         rx_ready,
  input  logic                         attr,
  output logic [COL_BITS+ROW_BITS-1:0] vram_ada,
  output logic [8:0]                   vram_dina,
  output logic                         vram_wrea,
  output logic                         vram_cea,
  output logic [ROW_BITS-1:0]          scroll_row,
  output logic [COL_BITS-1:0]          cur_col,
  output logic [ROW_BITS-1:0]          cur_row,
  output logic                         busy
);

  localparam int AW = COL_BITS + ROW_BITS;
  localparam logic [COL_BITS-1:0] LAST_COL  = '1;
  localparam logic [ROW_BITS-1:0] LAST_ROW  = '1;
  localparam logic [AW-1:0]       LAST_ADDR = '1;

  typedef enum logic [1:0] {
    ST_CLR_ALL,
    ST_IDLE,
    ST_WRITE,
    ST_CLR_LINE
  } state_e;

  state_e              state_q, state_d;
  logic [AW-1:0]       cnt_q, cnt_d;
  logic                rx_ready_q, rx_ready_d;
  logic                wrea_q, wrea_d;
  logic [AW-1:0]       ada_q, ada_d;
  logic [8:0]          dina_q, dina_d;
  logic [ROW_BITS-1:0] scroll_q, scroll_d;
  logic [COL_BITS-1:0] col_q, col_d;
  logic [ROW_BITS-1:0] row_q, row_d;
  logic                busy_q, busy_d;

  logic                accept;
  logic                printable;
  logic                do_newline;
  logic [ROW_BITS-1:0] phys_row;

  assign accept    = (state_q == ST_IDLE) && rx_valid && rx_ready_q;
  assign printable = (rx_data >= 8'h20) && (rx_data <= 8'h7E);
  assign phys_row  = row_q + scroll_q;

  // State and output registers; reset aborts any clear and restarts the
  // full-screen clear from address 0.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_CLR_ALL;
      cnt_q      <= '0;
      rx_ready_q <= 1'b0;
      wrea_q     <= 1'b0;
      ada_q      <= '0;
      dina_q     <= BLANK_WORD;
      scroll_q   <= '0;
      col_q      <= '0;
      row_q      <= '0;
      busy_q     <= 1'b1;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      rx_ready_q <= rx_ready_d;
      wrea_q     <= wrea_d;
      ada_q      <= ada_d;
      dina_q     <= dina_d;
      scroll_q   <= scroll_d;
      col_q      <= col_d;
      row_q      <= row_d;
      busy_q     <= busy_d;
    end
  end

  // Next-state and registered-output logic. Every write is registered, so
  // the RAM sees a word one cycle after the state that produced it.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    rx_ready_d = 1'b0;
    wrea_d     = 1'b0;
    ada_d      = ada_q;
    dina_d     = dina_q;
    scroll_d   = scroll_q;
    col_d      = col_q;
    row_d      = row_q;
    busy_d     = busy_q;
    do_newline = 1'b0;

    case (state_q)
      ST_CLR_ALL: begin
        wrea_d = 1'b1;
        ada_d  = cnt_q;
        dina_d = BLANK_WORD;
        busy_d = 1'b1;
        cnt_d  = cnt_q + AW'(1);
        if (cnt_q == LAST_ADDR) begin
          state_d    = ST_IDLE;
          col_d      = '0;
          row_d      = '0;
          scroll_d   = '0;
          rx_ready_d = 1'b1;
          busy_d     = 1'b0;
        end
      end

      ST_IDLE: begin
        rx_ready_d = 1'b1;
        busy_d     = 1'b0;
        if (accept) begin
          if (printable) begin
            // The character is written in the following cycle, while the
            // WRITE state holds off the next byte and moves the cursor.
            state_d    = ST_WRITE;
            rx_ready_d = 1'b0;
            wrea_d     = 1'b1;
            ada_d      = {phys_row, col_q};
            dina_d     = {attr, rx_data};
          end else begin
            case (rx_data)
              8'h0D: col_d = '0;
              8'h0A: do_newline = 1'b1;
              8'h08: if (col_q != '0) col_d = col_q - COL_BITS'(1);
              8'h0C: begin
                state_d    = ST_CLR_ALL;
                cnt_d      = '0;
                rx_ready_d = 1'b0;
                busy_d     = 1'b1;
              end
              default: ;
            endcase
          end
        end
      end

      ST_WRITE: begin
        state_d    = ST_IDLE;
        rx_ready_d = 1'b1;
        if (col_q == LAST_COL) begin
          col_d      = '0;
          do_newline = 1'b1;
        end else begin
          col_d = col_q + COL_BITS'(1);
        end
      end

      ST_CLR_LINE: begin
        // scroll_q already holds the new offset, so the old top row is
        // scroll_q - 1, written here as scroll_q + LAST_ROW (mod 32).
        wrea_d = 1'b1;
        ada_d  = {scroll_q + LAST_ROW, cnt_q[COL_BITS-1:0]};
        dina_d = BLANK_WORD;
        busy_d = 1'b1;
        cnt_d  = cnt_q + AW'(1);
        if (cnt_q[COL_BITS-1:0] == LAST_COL) begin
          state_d    = ST_IDLE;
          rx_ready_d = 1'b1;
          busy_d     = 1'b0;
        end
      end

      default: state_d = ST_CLR_ALL;
    endcase

    // Newline from LF or auto-wrap: move down, or scroll at the bottom
    // line and blank the row that becomes the new bottom line.
    if (do_newline) begin
      if (row_q != LAST_ROW) begin
        row_d = row_q + ROW_BITS'(1);
      end else begin
        scroll_d   = scroll_q + ROW_BITS'(1);
        state_d    = ST_CLR_LINE;
        cnt_d      = '0;
        rx_ready_d = 1'b0;
        busy_d     = 1'b1;
      end
    end
  end

  assign rx_ready   = rx_ready_q;
  assign vram_ada   = ada_q;
  assign vram_dina  = dina_q;
  assign vram_wrea  = wrea_q;
  assign vram_cea   = wrea_q;
  assign scroll_row = scroll_q;
  assign cur_col    = col_q;
  assign cur_row    = row_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_vram_term_writer.sv
// Self-checking bench for vram_term_writer. A reference model of the
// cursor/scroll state pushes every expected VRAM write into a queue; a
// monitor pops and compares each write the DUT actually issues.
module tb_vram_term_writer;

  logic        clk;
  logic        reset;
  logic        rx_valid;
  logic [7:0]  rx_data;
  logic        rx_ready;
  logic        attr;
  logic [10:0] vram_ada;
  logic [8:0]  vram_dina;
  logic        vram_wrea;
  logic        vram_cea;
  logic [4:0]  scroll_row;
  logic [5:0]  cur_col;
  logic [4:0]  cur_row;
  logic        busy;

  int checks   = 0;
  int failures = 0;
  int popCount = 0;

  logic [19:0] sb[$];

  logic [5:0] mCol;
  logic [4:0] mRow;
  logic [4:0] mScroll;

  vram_term_writer dut (
    .clk       (clk),
    .reset     (reset),
    .rx_valid  (rx_valid),
    .rx_data   (rx_data),
    .rx_ready  (rx_ready),
    .attr      (attr),
    .vram_ada  (vram_ada),
    .vram_dina (vram_dina),
    .vram_wrea (vram_wrea),
    .vram_cea  (vram_cea),
    .scroll_row(scroll_row),
    .cur_col   (cur_col),
    .cur_row   (cur_row),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Scoreboard monitor: every write seen on port A must match the oldest
  // expected write, and the clock enable must follow the write enable.
  always @(negedge clk) begin
    logic [19:0] exp;
    if (vram_wrea === 1'b1 || vram_cea === 1'b1) begin
      checks++;
      if (vram_cea !== vram_wrea) begin
        failures++;
        $display("[TB] FAIL cea_eq_wrea: cea=%b wrea=%b", vram_cea, vram_wrea);
      end
      if (sb.size() == 0) begin
        failures++;
        $display("[TB] FAIL unexpected_write: ada=%h dina=%h expected none", vram_ada, vram_dina);
      end else begin
        exp = sb.pop_front();
        popCount++;
        if ({vram_ada, vram_dina} !== exp) begin
          failures++;
          $display("[TB] FAIL write: ada=%h dina=%h expected ada=%h dina=%h",
                   vram_ada, vram_dina, exp[19:9], exp[8:0]);
        end
      end
    end
  end

  task automatic pushClearAll();
    for (int a = 0; a < 2048; a++) sb.push_back({11'(a), 9'h020});
  endtask

  task automatic modelNewline();
    logic [4:0] oldTop;
    if (mRow != 5'd31) begin
      mRow = mRow + 5'd1;
    end else begin
      oldTop  = mScroll;
      mScroll = mScroll + 5'd1;
      for (int c = 0; c < 64; c++) sb.push_back({oldTop, 6'(c), 9'h020});
    end
  endtask

  task automatic modelByte(input logic [7:0] b, input logic a);
    logic [4:0] pr;
    if (b >= 8'h20 && b <= 8'h7E) begin
      pr = mRow + mScroll;
      sb.push_back({pr, mCol, a, b});
      if (mCol == 6'd63) begin
        mCol = 6'd0;
        modelNewline();
      end else begin
        mCol = mCol + 6'd1;
      end
    end else if (b == 8'h0D) begin
      mCol = 6'd0;
    end else if (b == 8'h0A) begin
      modelNewline();
    end else if (b == 8'h08) begin
      if (mCol != 6'd0) mCol = mCol - 6'd1;
    end else if (b == 8'h0C) begin
      pushClearAll();
      mCol = 6'd0;
      mRow = 5'd0;
      mScroll = 5'd0;
    end
  endtask

  // Offers a byte until it is accepted; returns #1 after the accepting edge.
  task automatic sendByte(input logic [7:0] b, input logic a);
    int n;
    modelByte(b, a);
    rx_valid = 1'b1;
    rx_data  = b;
    attr     = a;
    n = 0;
    while (rx_ready !== 1'b1 && n < 5000) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 5000) begin
      failures++;
      $display("[TB] FAIL accept_timeout: rx_ready=%b expected 1", rx_ready);
    end
    @(posedge clk); #1;
    rx_valid = 1'b0;
  endtask

  task automatic waitIdle();
    int n;
    n = 0;
    while (!(sb.size() == 0 && rx_ready === 1'b1 && busy === 1'b0) && n < 5000) begin
      @(posedge clk); #1;
      n++;
    end
    checks++;
    if (n >= 5000) begin
      failures++;
      $display("[TB] FAIL idle_timeout: pending=%0d rx_ready=%b busy=%b expected 0/1/0",
               sb.size(), rx_ready, busy);
    end
  endtask

  task automatic checkCursor(input string tag);
    checks++;
    if (cur_col !== mCol || cur_row !== mRow || scroll_row !== mScroll) begin
      failures++;
      $display("[TB] FAIL %s: col=%0d row=%0d scroll=%0d expected col=%0d row=%0d scroll=%0d",
               tag, cur_col, cur_row, scroll_row, mCol, mRow, mScroll);
    end
  endtask

  task automatic test_reset();
    int cycles;
    int wc;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (rx_ready !== 1'b0 || vram_wrea !== 1'b0 || vram_cea !== 1'b0 || vram_ada !== 11'h000 ||
        vram_dina !== 9'h020 || busy !== 1'b1 || scroll_row !== 5'd0 || cur_col !== 6'd0 ||
        cur_row !== 5'd0) begin
      failures++;
      $display("[TB] FAIL reset_values: rdy=%b wrea=%b cea=%b ada=%h dina=%h busy=%b scr=%0d col=%0d row=%0d",
               rx_ready, vram_wrea, vram_cea, vram_ada, vram_dina, busy, scroll_row, cur_col, cur_row);
    end
    mCol = 6'd0;
    mRow = 5'd0;
    mScroll = 5'd0;
    pushClearAll();
    reset = 1'b0;
    cycles = 0;
    wc = 0;
    while (cycles < 3000) begin
      @(posedge clk); #1;
      cycles++;
      if (vram_wrea === 1'b1) wc++;
      if (rx_ready === 1'b1) break;
    end
    checks++;
    if (cycles !== 2048 || wc !== 2048) begin
      failures++;
      $display("[TB] FAIL clear_all_length: cycles=%0d writes=%0d expected 2048/2048", cycles, wc);
    end
    waitIdle();
    checkCursor("after_reset_cursor");
  endtask

  task automatic test_char();
    sendByte(8'h41, 1'b1);
    checks++;
    if (rx_ready !== 1'b0 || vram_wrea !== 1'b1 || vram_ada !== 11'h000 || vram_dina !== 9'h141) begin
      failures++;
      $display("[TB] FAIL char_write: rdy=%b wrea=%b ada=%h dina=%h expected 0/1/000/141",
               rx_ready, vram_wrea, vram_ada, vram_dina);
    end
    @(posedge clk); #1;
    checks++;
    if (rx_ready !== 1'b1 || vram_wrea !== 1'b0 || cur_col !== 6'd1) begin
      failures++;
      $display("[TB] FAIL char_after: rdy=%b wrea=%b col=%0d expected 1/0/1", rx_ready, vram_wrea, cur_col);
    end
    waitIdle();
    checkCursor("char_cursor");
  endtask

  task automatic test_wrap();
    sendByte(8'h0D, 1'b0);
    for (int i = 0; i < 64; i++) sendByte(8'h30 + 8'(i % 40), 1'(i % 2));
    waitIdle();
    checks++;
    if (cur_col !== 6'd0 || cur_row !== 5'd1) begin
      failures++;
      $display("[TB] FAIL wrap_cursor: col=%0d row=%0d expected 0/1", cur_col, cur_row);
    end
    checkCursor("wrap_model");
  endtask

  task automatic test_scroll();
    for (int i = 0; i < 30; i++) sendByte(8'h0A, 1'b0);
    waitIdle();
    checkCursor("row31_cursor");
    sendByte(8'h0A, 1'b0);
    checks++;
    if (busy !== 1'b1 || rx_ready !== 1'b0 || scroll_row !== 5'd1) begin
      failures++;
      $display("[TB] FAIL clr_line_start: busy=%b rdy=%b scroll=%0d expected 1/0/1", busy, rx_ready, scroll_row);
    end
    waitIdle();
    checks++;
    if (scroll_row !== 5'd1 || cur_row !== 5'd31) begin
      failures++;
      $display("[TB] FAIL scroll_end: scroll=%0d row=%0d expected 1/31", scroll_row, cur_row);
    end
    checkCursor("scroll_model");
  endtask

  task automatic test_controls();
    sendByte(8'h0D, 1'b0);
    sendByte(8'h08, 1'b0);
    checkCursor("bs_at_col0");
    sendByte(8'h07, 1'b0);
    checks++;
    if (rx_ready !== 1'b1 || busy !== 1'b0) begin
      failures++;
      $display("[TB] FAIL ignored_byte: rdy=%b busy=%b expected 1/0", rx_ready, busy);
    end
    checkCursor("ignored_byte_cursor");
    for (int i = 0; i < 10; i++) sendByte(8'h61 + 8'(i), 1'b0);
    waitIdle();
    checks++;
    if (cur_col !== 6'd10) begin
      failures++;
      $display("[TB] FAIL col10: col=%0d expected 10", cur_col);
    end
    sendByte(8'h08, 1'b0);
    waitIdle();
    checkCursor("bs_at_col10");
    sendByte(8'h0D, 1'b0);
    waitIdle();
    checkCursor("cr_cursor");
  endtask

  task automatic test_formfeed();
    sendByte(8'h5A, 1'b1);
    sendByte(8'h0C, 1'b0);
    checks++;
    if (busy !== 1'b1 || rx_ready !== 1'b0) begin
      failures++;
      $display("[TB] FAIL ff_start: busy=%b rdy=%b expected 1/0", busy, rx_ready);
    end
    waitIdle();
    checkCursor("ff_cursor");
  endtask

  task automatic test_reset_midclear();
    int base;
    int n;
    for (int i = 0; i < 31; i++) sendByte(8'h0A, 1'b0);
    waitIdle();
    base = popCount;
    sendByte(8'h0A, 1'b0);
    n = 0;
    while (popCount < base + 20 && n < 500) begin
      @(negedge clk);
      n++;
    end
    reset = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (vram_wrea !== 1'b0 || busy !== 1'b1 || rx_ready !== 1'b0 || vram_ada !== 11'h000) begin
      failures++;
      $display("[TB] FAIL midclear_reset: wrea=%b busy=%b rdy=%b ada=%h expected 0/1/0/000",
               vram_wrea, busy, rx_ready, vram_ada);
    end
    sb.delete();
    mCol = 6'd0;
    mRow = 5'd0;
    mScroll = 5'd0;
    pushClearAll();
    @(posedge clk); #1;
    reset = 1'b0;
    waitIdle();
    checkCursor("midclear_restart_cursor");
  endtask

  initial begin
    reset    = 1'b1;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    attr     = 1'b0;
    test_reset();
    test_char();
    test_wrap();
    test_scroll();
    test_controls();
    test_formfeed();
    test_reset_midclear();
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("[TB] FAIL leftover_writes: pending=%0d expected 0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
